// File: rtl/misao_mem_port.sv
// misao_mem_port: byte-wide memory slave for the MISA-O memory bus.
// Adds programmable read/write wait states, a ready handshake, a
// write-protected ROM window [0, ROM_TOP) and a sticky error flag with a
// saturating error counter.
// Optional feature: define MISAO_MEM_PARITY_EN to store an even-parity bit
// per location, check it on reads and add the inject_par input.
module misao_mem_port #(
  parameter int          ADDR_W  = 15,
  parameter int          DATA_W  = 8,
  parameter int          RD_LAT  = 1,
  parameter int          WR_LAT  = 0,
  parameter int unsigned ROM_TOP = 0
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MISAO_MEM_PARITY_EN
  input  logic              inject_par,
`endif
  input  logic              mem_enable_read,
  input  logic              mem_enable_write,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_err,
  output logic [7:0]        err_count
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef MISAO_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Kind of access captured when a waited request is accepted
  localparam logic [1:0] K_READ  = 2'd0;
  localparam logic [1:0] K_WRITE = 2'd1;
  localparam logic [1:0] K_ERR   = 2'd2;

  localparam logic [2:0] RD_CNT = 3'(RD_LAT);
  localparam logic [2:0] WR_CNT = 3'(WR_LAT);

  logic [MEM_W-1:0]  mem [DEPTH];

  logic [1:0]        state, state_d;
  logic [2:0]        cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        kind_q;
  logic [DATA_W-1:0] rdata_q;

  logic              req_any;
  logic              proto_err;
  logic [1:0]        req_kind;
  logic [2:0]        req_lat;
  logic [ADDR_W-1:0] access_addr;
  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  wr_word;
  logic              rom_hit;
  logic              par_bad;
  logic              capture;
  logic              do_write;
  logic              load_rdata;
  logic              err_event;

  // Request decode; a protocol error always uses the read latency
  assign req_any     = mem_enable_read | mem_enable_write;
  assign proto_err   = req_any & ((mem_enable_read & mem_enable_write) | (mem_rw != mem_enable_write));
  assign req_kind    = proto_err ? K_ERR : (mem_enable_write ? K_WRITE : K_READ);
  assign req_lat     = (req_kind == K_WRITE) ? WR_CNT : RD_CNT;

  // In IDLE the live address is used, afterwards the captured one
  assign access_addr = (state == S_IDLE) ? mem_addr : addr_q;
  assign rd_word     = mem[access_addr];

`ifdef MISAO_MEM_PARITY_EN
  assign wr_word = {(^mem_wdata) ^ inject_par, mem_wdata};
  assign par_bad = ^rd_word;
`else
  assign wr_word = mem_wdata;
  assign par_bad = 1'b0;
`endif

  generate
    if (ROM_TOP == 0) begin : g_no_rom
      assign rom_hit = 1'b0;
    end else begin : g_rom
      localparam logic [ADDR_W:0] ROM_LIM = ROM_TOP[ADDR_W:0];
      assign rom_hit = ({1'b0, access_addr} < ROM_LIM);
    end
  endgenerate

  // Zero-latency reads bypass the data register so data arrives with ready
  assign mem_rdata = (mem_ready && load_rdata) ? rd_word[DATA_W-1:0] : rdata_q;

  // Next-state logic and per-cycle access actions of the handshake FSM
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    capture    = 1'b0;
    mem_ready  = 1'b0;
    do_write   = 1'b0;
    load_rdata = 1'b0;
    err_event  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_any) begin
          if (req_lat == 3'd0) begin
            mem_ready = 1'b1;
            if (req_kind == K_ERR) begin
              err_event = 1'b1;
            end else if (req_kind == K_WRITE) begin
              if (rom_hit) err_event = 1'b1;
              else         do_write  = 1'b1;
            end else begin
              load_rdata = 1'b1;
              err_event  = par_bad;
            end
          end else begin
            state_d = S_WAIT;
            cnt_d   = req_lat;
            capture = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!req_any || (mem_addr != addr_q)) begin
          state_d   = S_IDLE;
          cnt_d     = 3'd0;
          err_event = 1'b1;
        end else if (cnt == 3'd1) begin
          state_d = S_RESP;
          cnt_d   = 3'd0;
          if (kind_q == K_READ) begin
            load_rdata = 1'b1;
            err_event  = par_bad;
          end
        end else begin
          cnt_d = cnt - 3'd1;
        end
      end
      S_RESP: begin
        mem_ready = 1'b1;
        state_d   = S_IDLE;
        if (kind_q == K_ERR) begin
          err_event = 1'b1;
        end else if (kind_q == K_WRITE) begin
          if (rom_hit) err_event = 1'b1;
          else         do_write  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      mem_ready  = 1'b0;
      do_write   = 1'b0;
      load_rdata = 1'b0;
    end
  end

  // FSM state, wait counter and the request captured on entry to WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 3'd0;
      addr_q <= '0;
      kind_q <= K_READ;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (capture) begin
        addr_q <= mem_addr;
        kind_q <= req_kind;
      end
    end
  end

  // Read data register, holds its value between read completions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else if (load_rdata) rdata_q <= rd_word[DATA_W-1:0];
  end

  // Sticky error flag and saturating error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_err   <= 1'b0;
      err_count <= 8'd0;
    end else if (err_event) begin
      mem_err <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  // Backing array; contents survive reset
  always_ff @(posedge clk) begin
    if (do_write) mem[access_addr] <= wr_word;
  end

endmodule

// File: tb/tb_misao_mem_port.sv
// tb_misao_mem_port: directed self-checking bench for misao_mem_port.
// dut0: RD_LAT=0, WR_LAT=2, no ROM window.
// dut1: RD_LAT=3, WR_LAT=2, ROM window [0,16).
module tb_misao_mem_port;

  logic            clk;
  logic            rst;
  logic [1:0]      req_rd, req_wr, req_rw;
  logic [1:0][7:0] addr, wdata;

  logic [7:0] rdat0, rdat1, ecnt0, ecnt1;
  logic       rdy0, rdy1, err0, err1;

  int total;
  int bad;

  always #5 clk = ~clk;

  misao_mem_port #(.ADDR_W(8), .DATA_W(8), .RD_LAT(0), .WR_LAT(2), .ROM_TOP(0)) dut0 (
    .clk(clk), .rst(rst),
`ifdef MISAO_MEM_PARITY_EN
    .inject_par(1'b0),
`endif
    .mem_enable_read(req_rd[0]), .mem_enable_write(req_wr[0]), .mem_rw(req_rw[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdat0),
    .mem_ready(rdy0), .mem_err(err0), .err_count(ecnt0)
  );

  misao_mem_port #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3), .WR_LAT(2), .ROM_TOP(16)) dut1 (
    .clk(clk), .rst(rst),
`ifdef MISAO_MEM_PARITY_EN
    .inject_par(1'b0),
`endif
    .mem_enable_read(req_rd[1]), .mem_enable_write(req_wr[1]), .mem_rw(req_rw[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdat1),
    .mem_ready(rdy1), .mem_err(err1), .err_count(ecnt1)
  );

  // Backdoor load of the ROM-window instance (stimulus only)
  task automatic preload(input logic [7:0] a, input logic [7:0] v);
`ifdef MISAO_MEM_PARITY_EN
    dut1.mem[a] = {^v, v};
`else
    dut1.mem[a] = v;
`endif
  endtask

  // Drives one request (called at posedge+1), returns cycles to ready and read data
  task automatic do_access(input int d, input logic is_wr, input logic [7:0] a,
                           input logic [7:0] v, output int lat, output logic [7:0] rd);
    req_rd[d] = !is_wr;
    req_wr[d] = is_wr;
    req_rw[d] = is_wr;
    addr[d]   = a;
    wdata[d]  = v;
    lat = -1;
    rd  = 8'h00;
    #1;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #2;
      end
      if ((d == 0) ? rdy0 : rdy1) begin
        lat = k;
        rd  = (d == 0) ? rdat0 : rdat1;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_rd[d] = 1'b0;
    req_wr[d] = 1'b0;
    req_rw[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    total++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b%b expected 00", rdy0, rdy1); end
    total++; if (err0 !== 1'b0 || err1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b%b expected 00", err0, err1); end
    total++; if (ecnt0 !== 8'd0 || ecnt1 !== 8'd0) begin bad++; $display("[TB] FAIL reset_count: got %0h/%0h expected 0/0", ecnt0, ecnt1); end
    total++; if (rdat0 !== 8'd0 || rdat1 !== 8'd0) begin bad++; $display("[TB] FAIL reset_rdata: got %0h/%0h expected 0/0", rdat0, rdat1); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_comb_read();
    int lat; logic [7:0] rd;
    do_access(0, 1'b1, 8'd1, 8'h15, lat, rd);
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL preload_write_lat: got %0d expected 3", lat); end
    do_access(0, 1'b0, 8'd1, 8'h00, lat, rd);
    total++; if (lat !== 0) begin bad++; $display("[TB] FAIL comb_read_lat: got %0d expected 0", lat); end
    total++; if (rd !== 8'h15) begin bad++; $display("[TB] FAIL comb_read_data: got %0h expected 15", rd); end
    addr[0] = 8'd2;
    #1;
    total++; if (rdat0 !== 8'h15 || rdy0 !== 1'b0) begin bad++; $display("[TB] FAIL comb_read_hold: got %0h/%b expected 15/0", rdat0, rdy0); end
  endtask

  task automatic test_write_latency();
    int lat; logic [7:0] rd;
    do_access(0, 1'b1, 8'd10, 8'h34, lat, rd);
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL write_lat: got %0d expected 3", lat); end
    do_access(0, 1'b0, 8'd10, 8'h00, lat, rd);
    total++; if (lat !== 0 || rd !== 8'h34) begin bad++; $display("[TB] FAIL write_readback: got %0d/%0h expected 0/34", lat, rd); end
    do_access(0, 1'b0, 8'd1, 8'h00, lat, rd);
    total++; if (rd !== 8'h15) begin bad++; $display("[TB] FAIL write_neighbour: got %0h expected 15", rd); end
    total++; if (ecnt0 !== 8'd0 || err0 !== 1'b0) begin bad++; $display("[TB] FAIL write_noerr: got %0h/%b expected 0/0", ecnt0, err0); end
  endtask

  task automatic test_slow_read();
    int lat; logic [7:0] rd;
    do_access(1, 1'b0, 8'd5, 8'h00, lat, rd);
    total++; if (lat !== 4) begin bad++; $display("[TB] FAIL slow_read_lat: got %0d expected 4", lat); end
    total++; if (rd !== 8'hAB) begin bad++; $display("[TB] FAIL slow_read_data: got %0h expected ab", rd); end
    #1;
    total++; if (rdy1 !== 1'b0 || rdat1 !== 8'hAB) begin bad++; $display("[TB] FAIL slow_read_hold: got %b/%0h expected 0/ab", rdy1, rdat1); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] rd;
    do_access(1, 1'b1, 8'd40, 8'h66, lat, rd);
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL b2b_write_lat: got %0d expected 3", lat); end
    do_access(1, 1'b0, 8'd40, 8'h00, lat, rd);
    total++; if (lat !== 4 || rd !== 8'h66) begin bad++; $display("[TB] FAIL b2b_read1: got %0d/%0h expected 4/66", lat, rd); end
    do_access(1, 1'b0, 8'd5, 8'h00, lat, rd);
    total++; if (lat !== 4 || rd !== 8'hAB) begin bad++; $display("[TB] FAIL b2b_read2: got %0d/%0h expected 4/ab", lat, rd); end
    total++; if (ecnt1 !== 8'd0) begin bad++; $display("[TB] FAIL b2b_noerr: got %0h expected 0", ecnt1); end
  endtask

  task automatic test_rom_protect();
    int lat; logic [7:0] rd;
    do_access(1, 1'b1, 8'd3, 8'hFF, lat, rd);
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL rom_write_lat: got %0d expected 3", lat); end
    total++; if (err1 !== 1'b1 || ecnt1 !== 8'd1) begin bad++; $display("[TB] FAIL rom_err: got %b/%0h expected 1/1", err1, ecnt1); end
    do_access(1, 1'b0, 8'd3, 8'h00, lat, rd);
    total++; if (rd !== 8'h3C) begin bad++; $display("[TB] FAIL rom_unchanged: got %0h expected 3c", rd); end
  endtask

  task automatic test_abort();
    int seen;
    seen = 0;
    req_rd[1] = 1'b1; req_rw[1] = 1'b0; addr[1] = 8'd30;
    @(posedge clk); #1;
    addr[1] = 8'd31;
    @(posedge clk); #1;
    req_rd[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2;
      if (rdy1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("[TB] FAIL abort_ready: got %0d pulses expected 0", seen); end
    total++; if (ecnt1 !== 8'd2) begin bad++; $display("[TB] FAIL abort_count: got %0h expected 2", ecnt1); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    int lat; logic [7:0] rd; int pulses; int first;
    do_access(1, 1'b1, 8'd50, 8'h77, lat, rd);
    req_rd[1] = 1'b1; req_wr[1] = 1'b1; req_rw[1] = 1'b1; addr[1] = 8'd50; wdata[1] = 8'h00;
    pulses = 0;
    first  = -1;
    #1;
    for (int k = 0; k < 2000 && pulses < 301; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #2;
      end
      if (rdy1) begin
        if (first < 0) first = k;
        pulses++;
      end
    end
    @(posedge clk); #1;
    req_rd[1] = 1'b0; req_wr[1] = 1'b0; req_rw[1] = 1'b0;
    total++; if (first !== 4) begin bad++; $display("[TB] FAIL proto_ready_lat: got %0d expected 4", first); end
    total++; if (pulses !== 301) begin bad++; $display("[TB] FAIL proto_pulses: got %0d expected 301", pulses); end
    total++; if (ecnt1 !== 8'hFF || err1 !== 1'b1) begin bad++; $display("[TB] FAIL saturate: got %0h/%b expected ff/1", ecnt1, err1); end
    do_access(1, 1'b0, 8'd50, 8'h00, lat, rd);
    total++; if (lat !== 4 || rd !== 8'h77) begin bad++; $display("[TB] FAIL proto_no_write: got %0d/%0h expected 4/77", lat, rd); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] rd;
    req_wr[1] = 1'b1; req_rw[1] = 1'b1; addr[1] = 8'd20; wdata[1] = 8'hC3;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if (rdy1 !== 1'b0 || err1 !== 1'b0 || ecnt1 !== 8'd0) begin bad++; $display("[TB] FAIL midreset_outputs: got %b/%b/%0h expected 0/0/0", rdy1, err1, ecnt1); end
    total++; if (rdat1 !== 8'd0) begin bad++; $display("[TB] FAIL midreset_rdata: got %0h expected 0", rdat1); end
    repeat (2) @(posedge clk);
    #1;
    req_wr[1] = 1'b0; req_rw[1] = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    do_access(1, 1'b0, 8'd20, 8'h00, lat, rd);
    total++; if (lat !== 4 || rd !== 8'h5A) begin bad++; $display("[TB] FAIL midreset_array: got %0d/%0h expected 4/5a", lat, rd); end
    total++; if (ecnt1 !== 8'd0) begin bad++; $display("[TB] FAIL midreset_count: got %0h expected 0", ecnt1); end
  endtask

  // Test sequence
  initial begin
    total  = 0;
    bad    = 0;
    clk    = 1'b0;
    rst    = 1'b0;
    req_rd = '0;
    req_wr = '0;
    req_rw = '0;
    addr   = '0;
    wdata  = '0;
    preload(8'd3,  8'h3C);
    preload(8'd5,  8'hAB);
    preload(8'd20, 8'h5A);
    test_reset();
    test_comb_read();
    test_write_latency();
    test_slow_read();
    test_back_to_back();
    test_rom_protect();
    test_abort();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
